// File: rtl/alu_muldiv_seq_pkg.sv
// Shared constants for the multi-cycle MULTU/DIVU sequencer.
//   ALU_ADD / ALU_SUB : operation codes understood by the shared 32-bit ALU
//   OP_MULTU / OP_DIVU: encoding of the 'op' request input
//   state_t           : sequencer FSM states
package alu_muldiv_seq_pkg;
  localparam int ALU_CTRL_W = 5;
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 5'b00000;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 5'b00001;

  localparam logic OP_MULTU = 1'b0;
  localparam logic OP_DIVU  = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/alu_muldiv_seq_step.sv
// One MULTU/DIVU iteration (the muldiv step), purely combinational.
//   mode       : OP_MULTU (shift-add) or OP_DIVU (restoring divide)
//   pr         : P (multiply partial product) / R (divide remainder)
//   q          : Q (multiplier bits / quotient-dividend shift register)
//   md         : M (multiplicand) / D (divisor)
//   alu_result : ALU output for this cycle (P+M or {R,Q[31]}-D)
//   pr_next, q_next : working registers after the iteration
module alu_muldiv_seq_step
  import alu_muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             mode,
  input  logic [WIDTH-1:0] pr,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] md,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] pr_next,
  output logic [WIDTH-1:0] q_next
);
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] shifted;
  logic             carry;
  logic             take;

  always_comb begin
    s       = pr;
    carry   = 1'b0;
    shifted = {pr[WIDTH-2:0], q[WIDTH-1]};
    take    = 1'b0;
    pr_next = pr;
    q_next  = q;
    if (mode == OP_MULTU) begin
      // ALU has no carry-out; an unsigned wrap shows up as result < P.
      if (q[0]) begin
        s     = alu_result;
        carry = (alu_result < pr);
      end
      pr_next = {carry, s[WIDTH-1:1]};
      q_next  = {s[0], q[WIDTH-1:1]};
    end else begin
      // R[31] set means the shifted remainder is really 33 bits wide and
      // therefore always exceeds D; the ALU's modulo result is still correct.
      take    = pr[WIDTH-1] | (shifted >= md);
      pr_next = take ? alu_result : shifted;
      q_next  = {q[WIDTH-2:0], take};
    end
  end
endmodule

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned MULTU/DIVU controller that borrows the shared ALU for
// one iteration per cycle.
//   clk, rst_n        : clock, synchronous active-low reset
//   start, op         : request (taken only in IDLE), 0=MULTU 1=DIVU
//   src_a, src_b      : multiplicand/dividend, multiplier/divisor
//   busy, done        : busy during RUN, one-cycle done pulse with result
//   hi, lo            : product[63:32]/[31:0] or remainder/quotient
//   div_by_zero       : DIVU with src_b==0; held until next accepted start
//   alu_in1/2, alu_control, alu_result : ALU interface (ALU is external)
module alu_muldiv_seq
  import alu_muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  op,
  input  logic [WIDTH-1:0]      src_a,
  input  logic [WIDTH-1:0]      src_b,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH-1:0]      hi,
  output logic [WIDTH-1:0]      lo,
  output logic                  div_by_zero,
  output logic [WIDTH-1:0]      alu_in1,
  output logic [WIDTH-1:0]      alu_in2,
  output logic [ALU_CTRL_W-1:0] alu_control,
  input  logic [WIDTH-1:0]      alu_result
);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q, md_q;
  logic [WIDTH-1:0] pr_next, q_next;
  logic             op_q;
  logic             dbz_q;
  logic             dbz_req;
  logic             last;

  assign dbz_req = (op == OP_DIVU) && (src_b == '0);
  assign last    = (cnt_q == CNT_W'(WIDTH-1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = dbz_req ? DONE : RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ALU is only ours during RUN; park it at ADD 0+0 otherwise.
  always_comb begin
    alu_in1     = '0;
    alu_in2     = '0;
    alu_control = ALU_ADD;
    if (state_q == RUN) begin
      alu_in2 = md_q;
      if (op_q == OP_MULTU) begin
        alu_in1 = hi_q;
      end else begin
        alu_in1     = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
        alu_control = ALU_SUB;
      end
    end
  end

  alu_muldiv_seq_step #(.WIDTH(WIDTH)) u_step (
    .mode       (op_q),
    .pr         (hi_q),
    .q          (lo_q),
    .md         (md_q),
    .alu_result (alu_result),
    .pr_next    (pr_next),
    .q_next     (q_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      md_q    <= '0;
      op_q    <= OP_MULTU;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (start) begin
          op_q  <= op;
          cnt_q <= '0;
          if (dbz_req) begin
            hi_q  <= src_a;
            lo_q  <= '1;
            dbz_q <= 1'b1;
          end else begin
            dbz_q <= 1'b0;
            hi_q  <= '0;
            lo_q  <= (op == OP_DIVU) ? src_a : src_b;
            md_q  <= (op == OP_DIVU) ? src_b : src_a;
          end
        end
        RUN: begin
          hi_q  <= pr_next;
          lo_q  <= q_next;
          cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq: vector table plus hand sequences for
// reset, divide-by-zero hold, start-during-RUN and reset-during-RUN.
module tb_alu_muldiv_seq;
  import alu_muldiv_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] src_a = '0, src_b = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo, alu_in1, alu_in2, alu_result;
  logic [4:0]  alu_control;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  // External ALU model: add / sub modulo 2^32.
  assign alu_result = (alu_control == 5'b00001) ? (alu_in1 - alu_in2) : (alu_in1 + alu_in2);

  alu_muldiv_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_control(alu_control),
    .alu_result(alu_result)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Issue one request, then walk cycles t+1.. until done (bounded).
  // inject>0 pulses a different start request in RUN cycle 'inject'.
  task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                        input int inject, output int lat, output int nbusy,
                        output logic alu_ok);
    @(negedge clk);
    op = o; src_a = a; src_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; nbusy = 0; alu_ok = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      if (n == inject) begin
        start = 1'b1; op = ~o; src_a = 32'd99; src_b = 32'd3;
      end else begin
        start = 1'b0;
      end
      if (busy) begin
        nbusy++;
        if (alu_control !== ((o == OP_DIVU) ? 5'b00001 : 5'b00000)) alu_ok = 1'b0;
      end else if (alu_control !== 5'b00000 || alu_in1 !== 32'd0 || alu_in2 !== 32'd0) begin
        alu_ok = 1'b0;
      end
      if (done) begin
        lat = n;
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  typedef struct {
    logic        op;
    logic [31:0] a, b, ehi, elo;
    logic        edbz;
    int          elat;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];

  int   lat, nb, quiet_done;
  logic ok;

  initial begin
    vecs[0] = '{1'b0, 32'd5,          32'd7,          32'd0,          32'd35,         1'b0, 33};
    vecs[1] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'h0000_0001,  1'b0, 33};
    vecs[2] = '{1'b1, 32'd100,        32'd7,          32'd2,          32'd14,         1'b0, 33};
    vecs[3] = '{1'b1, 32'hFFFF_FFFF,  32'h8000_0001,  32'h7FFF_FFFE,  32'd1,          1'b0, 33};
    vecs[4] = '{1'b1, 32'd1234,       32'd0,          32'd1234,       32'hFFFF_FFFF,  1'b1, 1};
    vecs[5] = '{1'b0, 32'h0001_0000,  32'h0001_0000,  32'd1,          32'd0,          1'b0, 33};
    vecs[6] = '{1'b0, 32'h8000_0000,  32'd2,          32'd1,          32'd0,          1'b0, 33};
    vecs[7] = '{1'b1, 32'd7,          32'd100,        32'd7,          32'd0,          1'b0, 33};
    vecs[8] = '{1'b1, 32'hFFFF_FFFF,  32'd1,          32'd0,          32'hFFFF_FFFF,  1'b0, 33};
    vecs[9] = '{1'b0, 32'd0,          32'd12345,      32'd0,          32'd0,          1'b0, 33};

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_dbz", div_by_zero, 0);
    chk("rst_alu_ctrl", alu_control, 0);
    rst_n = 1'b1;

    // Table-driven operations
    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, lat, nb, ok);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].elat);
      chk($sformatf("v%0d_busy_cycles", i), nb, (vecs[i].elat == 1) ? 0 : 32);
      chk($sformatf("v%0d_alu_drive", i), ok, 1);
      chk($sformatf("v%0d_hi", i), hi, vecs[i].ehi);
      chk($sformatf("v%0d_lo", i), lo, vecs[i].elo);
      chk($sformatf("v%0d_dbz", i), div_by_zero, vecs[i].edbz);
      @(posedge clk); #1;
      chk($sformatf("v%0d_single_pulse", i), done, 0);
      chk($sformatf("v%0d_hi_hold", i), hi, vecs[i].ehi);
      chk($sformatf("v%0d_lo_hold", i), lo, vecs[i].elo);
    end

    // Divide-by-zero flag held while idle, cleared by next accepted start
    run_op(OP_DIVU, 32'd1234, 32'd0, 0, lat, nb, ok);
    chk("dbz_latency", lat, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("dbz_hold", div_by_zero, 1);
    chk("dbz_hi_hold", hi, 32'd1234);
    @(negedge clk);
    op = OP_MULTU; src_a = 32'd2; src_b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("dbz_clear_on_start", div_by_zero, 0);
    quiet_done = 0;
    for (int n = 0; n < 40 && quiet_done == 0; n++) begin
      if (done) quiet_done = 1;
      else begin @(posedge clk); #1; end
    end
    chk("dbz_followup_lo", lo, 32'd6);

    // Start during RUN is ignored and not queued
    @(posedge clk); #1;
    run_op(OP_MULTU, 32'd5, 32'd7, 5, lat, nb, ok);
    chk("ign_latency", lat, 33);
    chk("ign_alu_drive", ok, 1);
    chk("ign_hi", hi, 0);
    chk("ign_lo", lo, 35);
    @(posedge clk); #1;
    chk("ign_single_pulse", done, 0);
    chk("ign_not_queued", busy, 0);

    // Reset during RUN aborts with no done
    @(negedge clk);
    op = OP_MULTU; src_a = 32'd5; src_b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    chk("midrst_busy_before", busy, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    quiet_done = 0;
    for (int n = 0; n < 40; n++) begin
      if (done || busy) quiet_done++;
      @(posedge clk); #1;
    end
    chk("midrst_no_done", quiet_done, 0);
    run_op(OP_MULTU, 32'd3, 32'd4, 0, lat, nb, ok);
    chk("midrst_fresh_latency", lat, 33);
    chk("midrst_fresh_lo", lo, 32'd12);
    chk("midrst_fresh_hi", hi, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Multi-cycle controller that runs unsigned MULTU/DIVU by sequencing the shared 32-bit ALU (add code 5'b00000, sub code 5'b00001) for one iteration per cycle.
- Sits between decode/execute and the ALU. Owns the ALU inputs during operation and writes the 64-bit result to HI/LO.
- Start/busy/done handshake to the pipeline stall logic.

Parameters:
- WIDTH, 32, operand width; the iteration count equals WIDTH. Only 32 is supported.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  request; accepted only in IDLE
- op  in  1  0 = MULTU, 1 = DIVU; sampled with start
- src_a  in  32  multiplicand / dividend
- src_b  in  32  multiplier / divisor
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse when hi/lo are valid
- hi  out  32  MULTU: product[63:32]; DIVU: remainder
- lo  out  32  MULTU: product[31:0]; DIVU: quotient
- div_by_zero  out  1  set with done on DIVU with src_b==0; held until next accepted start
- alu_in1  out  32  ALU operand 1
- alu_in2  out  32  ALU operand 2
- alu_control  out  5  ALU operation code
- alu_result  in  32  ALU combinational result, same cycle

Behaviour:
Reset:
- Synchronous: rst_n low at a rising edge forces IDLE, busy=0, done=0, hi=0, lo=0, div_by_zero=0, counter=0.
- Reset mid-RUN aborts the operation and produces no done pulse.

FSM:
- States are IDLE, RUN, DONE.
- IDLE, start=1, DIVU, src_b==0: go to DONE. hi<=src_a, lo<=32'hFFFF_FFFF, div_by_zero<=1.
- IDLE, start=1, any other case: latch the operand registers, counter<=0, go to RUN.
- RUN: one iteration per cycle. After the iteration with counter==WIDTH-1, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. Start is ignored in RUN and DONE; there is no queueing.

Latency and result hold:
- Start accepted at edge t: busy is 1 for cycles t+1..t+32, done is 1 in cycle t+33, and hi/lo are valid in that cycle.
- Divide-by-zero: done in cycle t+1.
- hi/lo hold their value until the next accepted start.
- hi/lo are not defined to the bench during RUN (they are the internal working registers).

ALU drive:
- Outside RUN: alu_in1=0, alu_in2=0, alu_control=5'b00000.

MULTU iteration (working registers: P=hi, Q=lo starting as src_b, M=src_a, P starting at 0):
- alu_in1=P, alu_in2=M, alu_control=ADD.
- If Q[0]: s=alu_result and carry=(alu_result < P), unsigned local compare. Otherwise s=P and carry=0.
- {P,Q} <= {carry, s, Q} >> 1, keeping 64 bits.

DIVU iteration (restoring; R=hi starting at 0, Q=lo starting as src_a, D=src_b):
- alu_in1={R[30:0],Q[31]}, alu_in2=D, alu_control=SUB.
- take = R[31] | (alu_in1 >= D), unsigned.
- R <= take ? alu_result : alu_in1.
- Q <= {Q[30:0], take}.

Other rules:
- All arithmetic is unsigned and modulo 2^32 per ALU op. The ALU has no carry/borrow output; the controller derives both locally.
- op/src_a/src_b changes during RUN have no effect.

Decomposition:
- Shared package holds the ALU control constants:
  - ALU_ADD=5'b00000
  - ALU_SUB=5'b00001
  - ALU_CTRL_W=5
- The package also holds the state encoding IDLE/RUN/DONE and the op encoding OP_MULTU=0, OP_DIVU=1.
- The ALU is instantiated outside this block. The sequencer only drives its ports.
- Natural sub-module: muldiv_step, purely combinational. Given mode, P/R, Q, M/D and alu_result, it produces the next P/R and Q. The FSM/counter remains in the top.

Test Plan:
- MULTU src_a=5, src_b=7 at edge t -> busy cycles t+1..t+32; done in t+33 with hi=0, lo=35; alu_control=00000 throughout RUN.
- MULTU 32'hFFFF_FFFF x 32'hFFFF_FFFF -> hi=32'hFFFF_FFFE, lo=32'h0000_0001 (exercises the carry path).
- DIVU 100/7 -> lo=14, hi=2, div_by_zero=0. DIVU 32'hFFFF_FFFF/32'h8000_0001 -> lo=1, hi=32'h7FFF_FFFE (exercises the R[31] take path).
- DIVU 1234/0 -> done in cycle t+1, hi=1234, lo=32'hFFFF_FFFF, div_by_zero=1. The next accepted start clears div_by_zero.
- Start pulsed at RUN cycle 5 with different operands -> ignored; the result matches the first op and a single done pulse occurs.
- rst_n=0 at RUN cycle 10 -> next edge: busy=0, hi=lo=0, no done. Then a fresh MULTU 3x4 gives lo=12 after 33 cycles.
